// File: rtl/mult_div_unit.sv
// mult_div_unit
// Sequential signed multiply/divide unit for the multicycle MIPS datapath.
// Handles one bit per clock, so an operation takes DATA_W iterations plus one
// finishing cycle. The control unit pulses start with op, waits on busy and
// consumes the done pulse. The 64-bit result is presented on hi/lo.
//
// Ports:
//   clock    - system clock, all state updates on the rising edge
//   reset    - asynchronous, active-low; clears all state
//   start    - request pulse, only honoured while idle
//   op       - 0 = signed MULT, 1 = signed DIV (sampled with start)
//   src_a    - multiplicand / dividend (sampled with start)
//   src_b    - multiplier / divisor (sampled with start)
//   hi       - MULT: product upper half, DIV: remainder
//   lo       - MULT: product lower half, DIV: quotient
//   busy     - registered, high while an operation is in progress
//   done     - one-cycle pulse when a result or exception is ready
//   div_zero - one-cycle pulse with done for a DIV by zero
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } stateT;

    stateT state;
    stateT nextState;

    // Working registers. accA is one bit wider than a data word so that the
    // Booth add/subtract of the most negative multiplicand cannot overflow;
    // for division it holds the partial remainder.
    logic [DATA_W:0]    accA;
    logic [DATA_W-1:0]  accQ;
    logic               qMinus1;
    logic [DATA_W-1:0]  operandM;
    logic [CNT_W-1:0]   counter;
    logic               opReg;
    logic               negQuot;
    logic               negRem;

    logic               divByZero;
    logic               accept;
    logic               doneNext;
    logic               divZeroNext;
    logic               busyNext;

    logic [DATA_W-1:0]  absA;
    logic [DATA_W-1:0]  absB;

    logic [DATA_W:0]    mExt;
    logic [DATA_W:0]    boothSum;
    logic [DATA_W:0]    partial;
    logic               fits;

    logic [DATA_W-1:0]  finHi;
    logic [DATA_W-1:0]  finLo;

    // State register: the only place the FSM state is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A DIV by zero is resolved in IDLE without ever entering RUN.
    assign divByZero = (state == IDLE) && start && op && (src_b == '0);
    assign accept    = (state == IDLE) && start && !divByZero;

    // Next-state logic. start outside IDLE is simply not looked at, which is
    // what makes a request during an operation harmless.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (counter == CNT_W'(1)) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Output logic: the values busy/done/div_zero take after the next edge.
    // They are registered below so the control unit sees clean flops.
    always_comb begin
        doneNext    = (state == FINISH) || divByZero;
        divZeroNext = divByZero;
        busyNext    = (nextState != IDLE);
    end

    // Operand magnitudes for restoring division; the most negative value
    // maps onto itself, which is its correct unsigned magnitude.
    assign absA = src_a[DATA_W-1] ? (~src_a + 1'b1) : src_a;
    assign absB = src_b[DATA_W-1] ? (~src_b + 1'b1) : src_b;

    // Booth step: inspect {Q[0], q-1}, add or subtract M, then the caller
    // shifts the whole {A, Q, q-1} register right arithmetically.
    assign mExt = {operandM[DATA_W-1], operandM};
    always_comb begin
        case ({accQ[0], qMinus1})
            2'b01:   boothSum = accA + mExt;
            2'b10:   boothSum = accA - mExt;
            default: boothSum = accA;
        endcase
    end

    // Restoring division step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if the divisor fits.
    assign partial = {accA[DATA_W-1:0], accQ[DATA_W-1]};
    assign fits    = (partial >= {1'b0, operandM});

    // Final result with sign correction for division. The quotient is
    // negated when operand signs differ; the remainder follows the dividend.
    always_comb begin
        if (opReg) begin
            finLo = negQuot ? (~accQ + 1'b1) : accQ;
            finHi = negRem ? (~accA[DATA_W-1:0] + 1'b1) : accA[DATA_W-1:0];
        end else begin
            finLo = accQ;
            finHi = accA[DATA_W-1:0];
        end
    end

    // Datapath and registered outputs. Operands are captured only at the
    // accepting edge, so later changes on src_a/src_b have no effect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            accA     <= '0;
            accQ     <= '0;
            qMinus1  <= 1'b0;
            operandM <= '0;
            counter  <= '0;
            opReg    <= 1'b0;
            negQuot  <= 1'b0;
            negRem   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= busyNext;
            done     <= doneNext;
            div_zero <= divZeroNext;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg   <= op;
                        counter <= CNT_W'(DATA_W);
                        accA    <= '0;
                        qMinus1 <= 1'b0;
                        negQuot <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
                        negRem  <= src_a[DATA_W-1];
                        if (op) begin
                            operandM <= absB;
                            accQ     <= absA;
                        end else begin
                            operandM <= src_a;
                            accQ     <= src_b;
                        end
                    end
                end
                RUN: begin
                    counter <= counter - 1'b1;
                    if (opReg) begin
                        accA <= fits ? (partial - {1'b0, operandM}) : partial;
                        accQ <= {accQ[DATA_W-2:0], fits};
                    end else begin
                        accA    <= {boothSum[DATA_W], boothSum[DATA_W:1]};
                        accQ    <= {boothSum[0], accQ[DATA_W-1:1]};
                        qMinus1 <= accQ[0];
                    end
                end
                FINISH: begin
                    hi <= finHi;
                    lo <= finLo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
